atan2_cordic_q824: RTL and testbench



---
 rtl/atan2_cordic_q824.sv | 148 ++++++++++++++
 tb/tb_atan2_cordic_q824.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/atan2_cordic_q824.sv
// Sequential CORDIC vectoring engine: Q8.24 (x, y) -> atan2(y, x) and gain-corrected magnitude.
// One operation in flight, valid/ready handshake on both sides.
module atan2_cordic_q824 #(
  parameter int          ITER = 24,
  parameter logic [31:0] KINV = 32'h009B74EE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] angle_out,
  output logic [31:0] mag_out
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // PRE   | quadrant fold into the right half-plane
  // ROT   | one micro-rotation per cycle, cnt = 0..ITER-1
  // SCALE | gain correction, register results
  // DONE  | result presented until out_ready
  typedef enum logic [2:0] {IDLE, PRE, ROT, SCALE, DONE} state_t;

  localparam logic signed [31:0] HALF_PI = 32'sh01921FB6;

  state_t             state;
  logic signed [35:0] x_r, y_r;
  logic signed [31:0] z_r;
  logic [4:0]         cnt;

  logic signed [35:0] x_sh, y_sh;
  logic signed [55:0] x_ext, k_ext, prod;
  logic [31:0]        mag;

  function automatic logic signed [31:0] atan_tab(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_tab = 32'sh00C90FDB;
      5'd1:    atan_tab = 32'sh0076B19C;
      5'd2:    atan_tab = 32'sh003EB6EC;
      5'd3:    atan_tab = 32'sh001FD5BB;
      5'd4:    atan_tab = 32'sh000FFAAE;
      5'd5:    atan_tab = 32'sh0007FF55;
      5'd6:    atan_tab = 32'sh0003FFEB;
      5'd7:    atan_tab = 32'sh0001FFFD;
      5'd8:    atan_tab = 32'sh00010000;
      5'd9:    atan_tab = 32'sh00008000;
      5'd10:   atan_tab = 32'sh00004000;
      5'd11:   atan_tab = 32'sh00002000;
      5'd12:   atan_tab = 32'sh00001000;
      5'd13:   atan_tab = 32'sh00000800;
      5'd14:   atan_tab = 32'sh00000400;
      5'd15:   atan_tab = 32'sh00000200;
      5'd16:   atan_tab = 32'sh00000100;
      5'd17:   atan_tab = 32'sh00000080;
      5'd18:   atan_tab = 32'sh00000040;
      5'd19:   atan_tab = 32'sh00000020;
      5'd20:   atan_tab = 32'sh00000010;
      5'd21:   atan_tab = 32'sh00000008;
      5'd22:   atan_tab = 32'sh00000004;
      5'd23:   atan_tab = 32'sh00000002;
      default: atan_tab = 32'sh00000000;
    endcase
  endfunction

  assign in_ready = (state == IDLE);

  assign x_sh = x_r >>> cnt;
  assign y_sh = y_r >>> cnt;

  // Drop the two extra LSBs (truncation) before the gain multiply.
  assign x_ext = {{22{x_r[35]}}, x_r[35:2]};
  assign k_ext = {24'd0, KINV};
  assign prod  = x_ext * k_ext;
  assign mag   = 32'(prod >>> 24);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= {{2{x_in[31]}}, x_in, 2'b00};
            y_r   <= {{2{y_in[31]}}, y_in, 2'b00};
            state <= PRE;
          end
        end
        PRE: begin
          cnt <= '0;
          if (!x_r[35]) begin
            z_r <= '0;
          end else if (!y_r[35]) begin
            x_r <= y_r;
            y_r <= -x_r;
            z_r <= HALF_PI;
          end else begin
            x_r <= -y_r;
            y_r <= x_r;
            z_r <= -HALF_PI;
          end
          state <= ROT;
        end
        ROT: begin
          if (!y_r[35]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_tab(cnt);
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_tab(cnt);
          end
          if (cnt == 5'(ITER - 1)) begin
            cnt   <= '0;
            state <= SCALE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        SCALE: begin
          // A zero vector never rotates y away from zero, so z just accumulates; report 0.
          angle_out <= (x_r == '0) ? 32'd0 : z_r;
          mag_out   <= mag;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_cordic_q824.sv
// Self-checking bench for atan2_cordic_q824: directed vectors, an angle sweep and random
// operands compared against a real-arithmetic atan2/sqrt model, plus backpressure and reset abort.
module tb_atan2_cordic_q824;

  localparam int ITER = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] angle_out;
  logic [31:0] mag_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  atan2_cordic_q824 #(.ITER(ITER), .KINV(32'h009B74EE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    longint d;
    n_checks++;
    d = longint'(obs) - longint'(exp);
    if (d < -longint'(tol) || d > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) tol %0d", tag, obs, obs, exp, exp, tol);
    end
  endtask

  function automatic int q24(real v);
    return $rtoi(v * 16777216.0 + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic int model_angle(int x, int y);
    return q24($atan2(real'(y), real'(x)));
  endfunction

  function automatic int model_mag(int x, int y);
    real xr, yr;
    xr = real'(x);
    yr = real'(y);
    return $rtoi($sqrt(xr * xr + yr * yr) + 0.5);
  endfunction

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic run_op(input string tag, input int x, input int y, input int ea, input int em,
                        input bit early, input int hold);
    int lat;
    chk({tag, "_rdy"}, int'(in_ready), 1, 0);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in = $urandom;
    y_in = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, ITER + 2, 0);
    chk({tag, "_ang"}, int'(angle_out), ea, 64);
    chk({tag, "_mag"}, int'(mag_out), em, 256);
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ov"}, int'(out_valid), 1, 0);
      chk({tag, "_hold_rdy"}, int'(in_ready), 0, 0);
      chk({tag, "_hold_ang"}, int'(angle_out), ea, 64);
      chk({tag, "_hold_mag"}, int'(mag_out), em, 256);
      in_valid = (j == 1);
      x_in = 32'hFF000000;
      y_in = 32'h00400000;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_ov"}, int'(out_valid), 0, 0);
    chk({tag, "_post_rdy"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, ax, ay;
    real a;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", int'(in_ready), 1, 0);
    chk("rst_ov", int'(out_valid), 0, 0);
    chk("rst_ang", int'(angle_out), 0, 0);
    chk("rst_mag", int'(mag_out), 0, 0);

    run_op("p10", 32'h01000000, 32'h00000000, 32'h00000000, 32'h01000000, 1'b0, 0);
    run_op("p11", 32'h01000000, 32'h01000000, 32'h00C90FDB, 32'h016A09E6, 1'b0, 0);
    run_op("p01", 32'h00000000, 32'h01000000, 32'h01921FB6, 32'h01000000, 1'b0, 0);
    run_op("nx0", 32'hFF000000, 32'h00000000, 32'h03243F6B, 32'h01000000, 1'b0, 0);
    run_op("nhh", 32'hFF800000, 32'hFF800000, 32'hFDA4D070, 32'h00B504F3, 1'b0, 0);
    run_op("zero", 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 0);

    for (int k = 0; k < 7; k++) begin
      a = -1.0 + real'(k) / 3.0;
      run_op("sweep", q24($cos(a)), q24($sin(a)), q24(a), 32'h01000000, 1'b0, 0);
    end

    run_op("bp", 32'h00800000, 32'h01000000, model_angle(32'h00800000, 32'h01000000),
           model_mag(32'h00800000, 32'h01000000), 1'b0, 5);
    chk("bp_idle_rdy", int'(in_ready), 1, 0);
    @(posedge clk); #1;
    chk("bp_no_capture_rdy", int'(in_ready), 1, 0);
    chk("bp_no_capture_ov", int'(out_valid), 0, 0);

    run_op("early", 32'hFE000000, 32'h03000000, model_angle(32'hFE000000, 32'h03000000),
           model_mag(32'hFE000000, 32'h03000000), 1'b1, 0);

    for (int k = 0; k < 20; k++) begin
      do begin
        x = int'($urandom_range(0, 32'h40000000)) - 536870912;
        y = int'($urandom_range(0, 32'h40000000)) - 536870912;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
      end while (ax < 32'h00800000 && ay < 32'h00800000);
      run_op("rand", x, y, model_angle(x, y), model_mag(x, y), (k % 4) == 0, 0);
    end

    x_in = 32'h01000000;
    y_in = 32'h01000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ov", int'(out_valid), 0, 0);
    chk("abort_ang", int'(angle_out), 0, 0);
    chk("abort_mag", int'(mag_out), 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdy", int'(in_ready), 1, 0);
    chk("abort_ov2", int'(out_valid), 0, 0);
    run_op("after_rst", 32'h01000000, 32'h01000000, 32'h00C90FDB, 32'h016A09E6, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
